mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-cycle data memory between two requesters: CPU load/store port (P0) and
//  accelerator DMA port (P1). Sits between both masters and the DataMemory bus; owns the
//  memory-side read/write strobes. Fixed CPU priority, optional accelerator aging, and a
//  bounded accelerator lock for short bursts. One transaction per two cycles.
// PARAMETERS
//  ADDR_W    32  address width, both ports and memory side
//  DATA_W    32  data width
//  MAX_WAIT  8   aging threshold, cycles P1 may wait (ARB_AGING_EN only), >=1
//  LOCK_MAX  4   max consecutive P1 transactions under acc_lock, >=1
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  cpu_req     in   1       P0 request; hold with cmd stable until cpu_gnt
//  cpu_we      in   1       P0 1=write 0=read
//  cpu_addr    in   ADDR_W  P0 byte address
//  cpu_wdata   in   DATA_W  P0 write data
//  cpu_gnt     out  1       P0 grant pulse (1 cycle, = ACCESS cycle)
//  cpu_stall   out  1       cpu_req & ~cpu_gnt (combinational)
//  cpu_rvalid  out  1       P0 read data valid pulse
//  cpu_rdata   out  DATA_W  P0 read data, held until next P0 read completes
//  acc_req     in   1       P1 request; same rules as P0
//  acc_we      in   1       P1 1=write
//  acc_lock    in   1       P1 requests bus retention after this transaction
//  acc_addr    in   ADDR_W  P1 address
//  acc_wdata   in   DATA_W  P1 write data
//  acc_gnt     out  1       P1 grant pulse
//  acc_rvalid  out  1       P1 read data valid pulse
//  acc_rdata   out  DATA_W  P1 read data
//  mem_read    out  1       memory read strobe
//  mem_write   out  1       memory write strobe (memory writes at clk edge ending ACCESS)
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, combinational from mem_addr
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output 0 (incl. rdata regs); wait_cnt=0, lock_cnt=0, owner=P0.
//  - FSM: IDLE -> ACCESS when any req sampled; ACCESS -> IDLE always. No back-to-back ACCESS.
//  - IDLE edge: winner chosen, cmd (we/addr/wdata) latched into regs, owner reg set.
//  - ACCESS cycle: gnt_owner=1; mem_read=~we_r, mem_write=we_r; mem_addr/mem_wdata from regs.
//    Outside ACCESS mem_read=mem_write=0, mem_addr/mem_wdata hold last value.
//  - Read: mem_rdata captured at end of ACCESS into owner's rdata; rvalid_owner=1 in next
//    (IDLE) cycle. Latency req-sampled -> rvalid = 2 cycles. Writes: no rvalid.
//  - Requester may drop req in gnt cycle; req still high after gnt = new request.
//  - Arbitration, in order: (1) lock active & acc_req -> P1; (2) aging expired & acc_req -> P1;
//    (3) cpu_req -> P0; (4) acc_req -> P1.
//  - Lock: set when P1 granted with acc_lock=1; lock_cnt increments per locked P1 grant;
//    lock clears when acc_lock=0 at a P1 grant, acc_req=0 at arbitration, or lock_cnt==LOCK_MAX
//    (then lock_cnt=0 and P0 wins next arbitration if requesting).
//  - Simultaneous req, no lock/aging: P0 wins; P1 served next slot if P0 drops req.
//  - Reset mid-ACCESS: outputs clear immediately; in-flight write has no guaranteed effect;
//    no rvalid issued.
// CONFIGURATION
//  ARB_AGING_EN defined: wait_cnt (clog2(MAX_WAIT+1) bits) increments each cycle acc_req=1
//   and acc_gnt=0, saturates at MAX_WAIT; clears on acc_gnt; wait_cnt==MAX_WAIT forces rule (2).
//  ARB_AGING_EN undefined: no wait_cnt; rule (2) absent; P1 may starve under continuous cpu_req.
// TESTING
//  1 cpu write we=1 addr=0x10 wdata=0xDEADBEEF -> next cycle cpu_gnt=1, mem_write=1,
//    mem_addr=0x10; then cpu read 0x10 -> cpu_rvalid 2 cycles after req, cpu_rdata=0xDEADBEEF.
//  2 cpu_req and acc_req both rise cycle 0, both reads, cpu drops after gnt -> cpu_gnt cycle 1,
//    cpu_rvalid cycle 2, acc_gnt cycle 3, acc_rvalid cycle 4.
//  3 ARB_AGING_EN, MAX_WAIT=8, cpu_req and acc_req held high -> acc_gnt within 10 cycles,
//    then wait_cnt=0; without macro -> acc_gnt never asserts over 100 cycles.
//  4 acc_lock=1, 6 acc writes queued, cpu_req high throughout -> 4 consecutive acc_gnt
//    (LOCK_MAX), then cpu_gnt, then acc resumes.
//  5 reset asserted mid ACCESS of acc write -> mem_write, acc_gnt fall same cycle; after
//    release FSM=IDLE, no acc_rvalid, all outputs 0.
//  6 read then write by P1 -> acc_rdata keeps read value after write completes; cpu_rdata
//    unchanged throughout.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-cycle data memory: CPU (P0) and DMA (P1).
// Define ARB_AGING_EN to add accelerator aging; default build has none.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              lock_r, lock_nx;
    logic [LCW-1:0]    lock_cnt, lock_cnt_nx;
    logic              pick_acc;
    logic              age_hit;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    assign cpu_gnt   = (state == ACCESS) && !owner;
    assign acc_gnt   = (state == ACCESS) && owner;
    assign cpu_stall = cpu_req && !cpu_gnt;
    assign mem_read  = (state == ACCESS) && !we_r;
    assign mem_write = (state == ACCESS) && we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

`ifdef ARB_AGING_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt;

    assign age_hit = (wait_cnt == WCW'(MAX_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (acc_gnt)
            wait_cnt <= '0;
        else if (acc_req && !age_hit)
            wait_cnt <= wait_cnt + WCW'(1);
    end
`else
    assign age_hit = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        lock_nx     = lock_r;
        lock_cnt_nx = lock_cnt;
        pick_acc    = 1'b0;
        unique case (state)
            IDLE: begin
                // An idle accelerator gives up any retained lock.
                if (!acc_req) begin
                    lock_nx     = 1'b0;
                    lock_cnt_nx = '0;
                end
                if (cpu_req || acc_req) begin
                    pick_acc = acc_req && (lock_r || age_hit || !cpu_req);
                    state_nx = ACCESS;
                    owner_nx = pick_acc;
                    if (pick_acc && acc_lock) begin
                        if (lock_cnt == LCW'(LOCK_MAX - 1)) begin
                            lock_nx     = 1'b0;
                            lock_cnt_nx = '0;
                        end else begin
                            lock_nx     = 1'b1;
                            lock_cnt_nx = lock_cnt + LCW'(1);
                        end
                    end else if (pick_acc) begin
                        lock_nx     = 1'b0;
                        lock_cnt_nx = '0;
                    end
                end
            end
            ACCESS:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            lock_r   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            lock_r   <= lock_nx;
            lock_cnt <= lock_cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (state == IDLE && (cpu_req || acc_req)) begin
            we_r    <= pick_acc ? acc_we : cpu_we;
            addr_r  <= pick_acc ? acc_addr : cpu_addr;
            wdata_r <= pick_acc ? acc_wdata : cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            acc_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            acc_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            acc_rvalid <= 1'b0;
            if (state == ACCESS && !we_r) begin
                if (owner) begin
                    acc_rdata  <= mem_rdata;
                    acc_rvalid <= 1'b1;
                end else begin
                    cpu_rdata  <= mem_rdata;
                    cpu_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
